// File: rtl/aes_ctrl_pkg.sv
// Shared types and default sizes for the byte-serial AES control path.
package aes_ctrl_pkg;

   localparam int AES128_ROUNDS   = 10;
   localparam int AES_BLOCK_BYTES = 16;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      ROUND,
      FINAL,
      DRAIN
   } seq_state_t;

   typedef logic [3:0]                           round_idx_t;
   typedef logic [$clog2(AES_BLOCK_BYTES)-1:0]   byte_idx_t;

endpackage

// File: rtl/aes_valid_delay.sv
// Fixed-depth valid pipe mirroring the datapath latency of final-round bytes.
module aes_valid_delay #(
   parameter int DEPTH = 2
) (
   input  logic clk,
   input  logic clr,
   input  logic shift_in,
   output logic shift_out
);

   logic [DEPTH-1:0] pipe;

   always_ff @(posedge clk) begin
      if (clr) begin
         pipe <= '0;
      end else begin
         pipe[0] <= shift_in;
         for (int i = 1; i < DEPTH; i++) begin
            pipe[i] <= pipe[i-1];
         end
      end
   end

   assign shift_out = pipe[DEPTH-1];

endmodule

// File: rtl/aes_core_sequencer.sv
// Control sequencer for the byte-serial AES datapath: load pass, full rounds,
// final round and output drain, with every control strobe registered.
module aes_core_sequencer
   import aes_ctrl_pkg::*;
#(
   parameter int NUM_ROUNDS      = AES128_ROUNDS,
   parameter int BYTES_PER_BLOCK = AES_BLOCK_BYTES,
   parameter int DP_LATENCY      = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       decrypt,
   input  logic       in_valid,
   output logic       in_ready,
   output logic       key_start,
   output logic [3:0] key_round,
   output logic [3:0] key_byte,
   output logic       en_paralle_load,
   output logic       cipher,
   output logic       bpu_rst_synch,
   output logic       out_valid,
   output logic       done,
   output logic       err,
   output logic       busy
);

   localparam int                 CNT_W           = $clog2(BYTES_PER_BLOCK);
   localparam logic [CNT_W-1:0]   LAST_BYTE       = CNT_W'(BYTES_PER_BLOCK - 1);
   localparam logic [CNT_W-1:0]   LAST_DRAIN      = CNT_W'(DP_LATENCY - 1);
   localparam round_idx_t         LAST_FULL_ROUND = round_idx_t'(NUM_ROUNDS - 1);

   seq_state_t       state, nxt_state;
   logic [CNT_W-1:0] byte_cnt, nxt_cnt;
   round_idx_t       round, nxt_round;
   logic             accept, abort, final_pass;

   // byte_cnt doubles as the drain timer so done lands on the last out_valid
   always_comb begin
      nxt_state = state;
      nxt_cnt   = byte_cnt;
      nxt_round = round;
      accept    = 1'b0;
      abort     = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               accept    = 1'b1;
               nxt_state = LOAD;
               nxt_cnt   = '0;
               nxt_round = '0;
            end
         end
         LOAD: begin
            if (!in_valid) begin
               abort     = 1'b1;
               nxt_state = IDLE;
               nxt_cnt   = '0;
            end else if (byte_cnt == LAST_BYTE) begin
               nxt_cnt   = '0;
               nxt_round = 4'd1;
               nxt_state = (NUM_ROUNDS == 1) ? FINAL : ROUND;
            end else begin
               nxt_cnt = byte_cnt + CNT_W'(1);
            end
         end
         ROUND: begin
            if (byte_cnt == LAST_BYTE) begin
               nxt_cnt   = '0;
               nxt_round = round + 4'd1;
               if (round == LAST_FULL_ROUND) begin
                  nxt_state = FINAL;
               end
            end else begin
               nxt_cnt = byte_cnt + CNT_W'(1);
            end
         end
         FINAL: begin
            if (byte_cnt == LAST_BYTE) begin
               nxt_cnt   = '0;
               nxt_state = DRAIN;
            end else begin
               nxt_cnt = byte_cnt + CNT_W'(1);
            end
         end
         DRAIN: begin
            if (byte_cnt == LAST_DRAIN) begin
               nxt_cnt   = '0;
               nxt_state = IDLE;
            end else begin
               nxt_cnt = byte_cnt + CNT_W'(1);
            end
         end
         default: begin
            nxt_state = IDLE;
            nxt_cnt   = '0;
         end
      endcase
   end

   // Strobes decode the upcoming state/count so they line up with the byte on the bus
   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= IDLE;
         byte_cnt        <= '0;
         round           <= '0;
         cipher          <= 1'b1;
         key_start       <= 1'b0;
         in_ready        <= 1'b0;
         en_paralle_load <= 1'b0;
         bpu_rst_synch   <= 1'b0;
         done            <= 1'b0;
         err             <= 1'b0;
         busy            <= 1'b0;
      end else begin
         state           <= nxt_state;
         byte_cnt        <= nxt_cnt;
         round           <= nxt_round;
         if (accept) begin
            cipher <= ~decrypt;
         end
         key_start       <= accept;
         err             <= abort;
         busy            <= (nxt_state != IDLE);
         in_ready        <= (nxt_state == LOAD);
         en_paralle_load <= (nxt_state == ROUND) && (nxt_cnt[1:0] == 2'b11);
         bpu_rst_synch   <= ((nxt_state == LOAD) || (nxt_state == ROUND) || (nxt_state == FINAL))
                            && (nxt_cnt == LAST_BYTE);
         done            <= (nxt_state == DRAIN) && (nxt_cnt == LAST_DRAIN);
      end
   end

   assign final_pass = (state == FINAL);
   assign key_round  = round;
   assign key_byte   = 4'(byte_cnt);

   aes_valid_delay #(
      .DEPTH (DP_LATENCY)
   ) u_valid_delay (
      .clk       (clk),
      .clr       (rst),
      .shift_in  (final_pass),
      .shift_out (out_valid)
   );

endmodule

// File: tb/tb_aes_core_sequencer.sv
// Scoreboard bench: stimulus pushes expected strobe/output events, monitors pop and compare.
`timescale 1ns/1ps
module tb_aes_core_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, start, decrypt, in_valid;
   logic       in_ready, key_start, en_paralle_load, cipher, bpu_rst_synch;
   logic       out_valid, done, err, busy;
   logic [3:0] key_round, key_byte;

   logic       start2, decrypt2, in_valid2;
   logic       in_ready2, key_start2, en_paralle_load2, cipher2, bpu_rst_synch2;
   logic       out_valid2, done2, err2, busy2;
   logic [3:0] key_round2, key_byte2;

   aes_core_sequencer #(
      .NUM_ROUNDS      (10),
      .BYTES_PER_BLOCK (16),
      .DP_LATENCY      (2)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .start           (start),
      .decrypt         (decrypt),
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .key_start       (key_start),
      .key_round       (key_round),
      .key_byte        (key_byte),
      .en_paralle_load (en_paralle_load),
      .cipher          (cipher),
      .bpu_rst_synch   (bpu_rst_synch),
      .out_valid       (out_valid),
      .done            (done),
      .err             (err),
      .busy            (busy)
   );

   aes_core_sequencer #(
      .NUM_ROUNDS      (14),
      .BYTES_PER_BLOCK (16),
      .DP_LATENCY      (3)
   ) dut2 (
      .clk             (clk),
      .rst             (rst),
      .start           (start2),
      .decrypt         (decrypt2),
      .in_valid        (in_valid2),
      .in_ready        (in_ready2),
      .key_start       (key_start2),
      .key_round       (key_round2),
      .key_byte        (key_byte2),
      .en_paralle_load (en_paralle_load2),
      .cipher          (cipher2),
      .bpu_rst_synch   (bpu_rst_synch2),
      .out_valid       (out_valid2),
      .done            (done2),
      .err             (err2),
      .busy            (busy2)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp  = 0;
   int n_fail = 0;

   typedef struct { int cycle; int done; int cipher; } ov_exp_t;
   typedef struct { int cycle; int round; int byte_idx; } strobe_exp_t;
   typedef struct { int cycle; int cipher; } ks_exp_t;

   ov_exp_t     exp_ov[$];
   strobe_exp_t exp_epl[$];
   strobe_exp_t exp_bpu[$];
   ks_exp_t     exp_ks[$];
   int          exp_err[$];
   ov_exp_t     exp2_ov[$];
   strobe_exp_t exp2_bpu[$];

   localparam int NO_EVENT = -100;

   function automatic void compare(input string name, input int actual, input int expected);
      n_cmp++;
      if (actual !== expected) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
      end
   endfunction

   function automatic void unexpected(input string name);
      n_cmp++;
      n_fail++;
      $display("[TB] FAIL unexpected %s: got 1, expected 0 (cycle %0d)", name, cyc);
   endfunction

   // Default-parameter monitor: every strobe pulse must match the head of its queue
   always @(negedge clk) begin : mon1
      ov_exp_t     e;
      strobe_exp_t s;
      ks_exp_t     k;
      if (out_valid === 1'b1) begin
         if (exp_ov.size() == 0) unexpected("out_valid");
         else begin
            e = exp_ov.pop_front();
            compare("out_valid cycle", cyc, e.cycle);
            compare("done with out_valid", int'(done), e.done);
            compare("cipher at out_valid", int'(cipher), e.cipher);
            if (done === 1'b1) compare("busy at done", int'(busy), 1);
         end
      end else if (done === 1'b1) unexpected("done without out_valid");
      if (en_paralle_load === 1'b1) begin
         if (exp_epl.size() == 0) unexpected("en_paralle_load");
         else begin
            s = exp_epl.pop_front();
            compare("en_paralle_load cycle", cyc, s.cycle);
            compare("key_round at load", int'(key_round), s.round);
            compare("key_byte at load", int'(key_byte), s.byte_idx);
         end
      end
      if (bpu_rst_synch === 1'b1) begin
         if (exp_bpu.size() == 0) unexpected("bpu_rst_synch");
         else begin
            s = exp_bpu.pop_front();
            compare("bpu_rst_synch cycle", cyc, s.cycle);
            compare("key_round at bpu", int'(key_round), s.round);
            compare("key_byte at bpu", int'(key_byte), s.byte_idx);
         end
      end
      if (key_start === 1'b1) begin
         if (exp_ks.size() == 0) unexpected("key_start");
         else begin
            k = exp_ks.pop_front();
            compare("key_start cycle", cyc, k.cycle);
            compare("cipher at key_start", int'(cipher), k.cipher);
            compare("in_ready at key_start", int'(in_ready), 1);
         end
      end
      if (err === 1'b1) begin
         if (exp_err.size() == 0) unexpected("err");
         else begin
            compare("err cycle", cyc, exp_err.pop_front());
            compare("busy at err", int'(busy), 0);
            compare("in_ready at err", int'(in_ready), 0);
         end
      end
   end

   // Swept-parameter monitor
   always @(negedge clk) begin : mon2
      ov_exp_t     e;
      strobe_exp_t s;
      if (out_valid2 === 1'b1) begin
         if (exp2_ov.size() == 0) unexpected("sweep out_valid");
         else begin
            e = exp2_ov.pop_front();
            compare("sweep out_valid cycle", cyc, e.cycle);
            compare("sweep done with out_valid", int'(done2), e.done);
            compare("sweep cipher", int'(cipher2), e.cipher);
            if (done2 === 1'b1) compare("sweep busy at done", int'(busy2), 1);
         end
      end else if (done2 === 1'b1) unexpected("sweep done without out_valid");
      if (bpu_rst_synch2 === 1'b1) begin
         if (exp2_bpu.size() == 0) unexpected("sweep bpu_rst_synch");
         else begin
            s = exp2_bpu.pop_front();
            compare("sweep bpu cycle", cyc, s.cycle);
            compare("sweep key_round at bpu", int'(key_round2), s.round);
            compare("sweep key_byte at bpu", int'(key_byte2), s.byte_idx);
         end
      end
      if (err2 === 1'b1) unexpected("sweep err");
   end

   // Hand-derived timeline for 10 rounds / 16 bytes / latency 2, clipped at last_rel
   task automatic pushExpected(input int t0, input logic dec, input int last_rel, input int err_rel);
      ov_exp_t     e;
      strobe_exp_t s;
      ks_exp_t     k;
      k.cycle  = t0 + 1;
      k.cipher = dec ? 0 : 1;
      exp_ks.push_back(k);
      if (err_rel > 0) exp_err.push_back(t0 + err_rel);
      for (int i = 0; i < 36; i++) begin
         if (20 + 4 * i <= last_rel) begin
            s.cycle    = t0 + 20 + 4 * i;
            s.round    = 1 + i / 4;
            s.byte_idx = 3 + 4 * (i % 4);
            exp_epl.push_back(s);
         end
      end
      for (int i = 1; i <= 11; i++) begin
         if (16 * i <= last_rel) begin
            s.cycle    = t0 + 16 * i;
            s.round    = i - 1;
            s.byte_idx = 15;
            exp_bpu.push_back(s);
         end
      end
      for (int r = 163; r <= 178; r++) begin
         if (r <= last_rel) begin
            e.cycle  = t0 + r;
            e.done   = (r == 178) ? 1 : 0;
            e.cipher = dec ? 0 : 1;
            exp_ov.push_back(e);
         end
      end
   endtask

   // Drives one block on the default DUT; called at a negedge, returns at negedge t0+window
   task automatic applyStimulus(input logic dec, input int abort_byte, input int rst_rel,
                                input int pulse_a, input int pulse_b, input int window);
      int t0;
      int last_rel;
      t0 = cyc;
      last_rel = (rst_rel > 0) ? rst_rel : 1000;
      if (abort_byte >= 0) pushExpected(t0, dec, abort_byte + 1, abort_byte + 2);
      else                 pushExpected(t0, dec, last_rel, 0);
      start    = 1'b1;
      decrypt  = dec;
      in_valid = 1'b1;
      for (int r = 1; r < window; r++) begin
         @(negedge clk);
         start   = (r == pulse_a) || (r == pulse_b);
         decrypt = ~dec;
         rst     = (r == rst_rel);
         if (r == abort_byte + 1) in_valid = 1'b0;
      end
      @(negedge clk);
      start    = 1'b0;
      rst      = 1'b0;
      in_valid = 1'b0;
   endtask

   task automatic applySweep(input logic dec);
      int          t0;
      ov_exp_t     e;
      strobe_exp_t s;
      t0 = cyc;
      for (int i = 1; i <= 15; i++) begin
         s.cycle    = t0 + 16 * i;
         s.round    = i - 1;
         s.byte_idx = 15;
         exp2_bpu.push_back(s);
      end
      for (int r = 228; r <= 243; r++) begin
         e.cycle  = t0 + r;
         e.done   = (r == 243) ? 1 : 0;
         e.cipher = dec ? 0 : 1;
         exp2_ov.push_back(e);
      end
      start2    = 1'b1;
      decrypt2  = dec;
      in_valid2 = 1'b1;
      @(negedge clk);
      start2 = 1'b0;
      repeat (250) @(negedge clk);
      in_valid2 = 1'b0;
   endtask

   task automatic checkOutput(input string tag);
      $display("[TB] reset-value check: %s", tag);
      compare("rst in_ready", int'(in_ready), 0);
      compare("rst key_start", int'(key_start), 0);
      compare("rst en_paralle_load", int'(en_paralle_load), 0);
      compare("rst bpu_rst_synch", int'(bpu_rst_synch), 0);
      compare("rst out_valid", int'(out_valid), 0);
      compare("rst done", int'(done), 0);
      compare("rst err", int'(err), 0);
      compare("rst busy", int'(busy), 0);
      compare("rst cipher", int'(cipher), 1);
      compare("rst key_round", int'(key_round), 0);
      compare("rst key_byte", int'(key_byte), 0);
   endtask

   task automatic checkDrained(input string tag);
      $display("[TB] scoreboard drain check: %s", tag);
      compare("pending out_valid", exp_ov.size(), 0);
      compare("pending en_paralle_load", exp_epl.size(), 0);
      compare("pending bpu_rst_synch", exp_bpu.size(), 0);
      compare("pending key_start", exp_ks.size(), 0);
      compare("pending err", exp_err.size(), 0);
      compare("pending sweep out_valid", exp2_ov.size(), 0);
      compare("pending sweep bpu", exp2_bpu.size(), 0);
   endtask

   initial begin
      rst       = 1'b1;
      start     = 1'b0;
      decrypt   = 1'b0;
      in_valid  = 1'b0;
      start2    = 1'b0;
      decrypt2  = 1'b0;
      in_valid2 = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("power-on");
      rst = 1'b0;

      $display("[TB] nominal encrypt");
      applyStimulus(1'b0, NO_EVENT, 0, 0, 0, 185);
      checkDrained("encrypt");

      $display("[TB] nominal decrypt");
      applyStimulus(1'b1, NO_EVENT, 0, 0, 0, 185);
      checkDrained("decrypt");

      $display("[TB] load abort at byte 7, restart in err cycle");
      applyStimulus(1'b0, 7, 0, 0, 0, 9);
      applyStimulus(1'b1, NO_EVENT, 0, 0, 0, 185);
      checkDrained("abort+restart");

      $display("[TB] reset mid-round");
      applyStimulus(1'b1, NO_EVENT, 90, 0, 0, 91);
      checkOutput("after mid-round reset");
      repeat (150) @(negedge clk);
      checkDrained("mid-round reset");

      $display("[TB] start while busy");
      applyStimulus(1'b0, NO_EVENT, 0, 50, 170, 185);
      checkDrained("start while busy");

      $display("[TB] parameter sweep 14 rounds, latency 3");
      applySweep(1'b1);
      checkDrained("sweep");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
